// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: operand forwarding mux, bubble insertion on
// load-use stall or EX flush, and saturating stall/flush event counters.
module id_ex_pipe #(
    parameter int          CTRL_W = 8,
    parameter logic [31:0] NOP    = 32'h00000013,
    parameter int          CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ID_pc,
    input  logic [31:0]       ID_inst,
    input  logic [31:0]       ID_rd1,
    input  logic [31:0]       ID_rd2,
    input  logic [31:0]       ID_imm,
    input  logic              ID_rfwe,
    input  logic [1:0]        ID_wdsel,
    input  logic [CTRL_W-1:0] ID_ctrl,
    input  logic [1:0]        rd1_sel,
    input  logic [1:0]        rd2_sel,
    input  logic [31:0]       fw1,
    input  logic [31:0]       fw2,
    input  logic              dpc_control,
    input  logic              flush,
    output logic [31:0]       EX_pc,
    output logic [31:0]       EX_inst,
    output logic [31:0]       EX_rd1,
    output logic [31:0]       EX_rd2,
    output logic [31:0]       EX_imm,
    output logic              EX_rfwe,
    output logic [1:0]        EX_wdsel,
    output logic [CTRL_W-1:0] EX_ctrl,
    output logic              EX_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       inst;
        logic [31:0]       rd1;
        logic [31:0]       rd2;
        logic [31:0]       imm;
        logic              rfwe;
        logic [1:0]        wdsel;
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
    } id_ex_t;

    id_ex_t            ex_q, ex_d, ex_rst;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;
    logic              bubble;

    assign bubble = flush | dpc_control;

    always_comb begin
        ex_rst      = '0;
        ex_rst.inst = NOP;
    end

    always_comb begin
        ex_d.pc    = ID_pc;
        ex_d.inst  = ID_inst;
        ex_d.rd1   = (rd1_sel == 2'd1) ? fw1 : ID_rd1;
        ex_d.rd2   = (rd2_sel == 2'd1) ? fw2 : ID_rd2;
        ex_d.imm   = ID_imm;
        ex_d.rfwe  = ID_rfwe;
        ex_d.wdsel = ID_wdsel;
        ex_d.ctrl  = ID_ctrl;
        ex_d.valid = 1'b1;
        // The hazard unit matches EX_pc against ID_pc to spot its own bubble.
        if (bubble) begin
            ex_d      = ex_rst;
            ex_d.pc   = ID_pc;
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (flush && !(&flush_q))
            flush_d = flush_q + 1'b1;
        if (!flush && dpc_control && !(&stall_q))
            stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= ex_rst;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            ex_q    <= ex_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign EX_pc     = ex_q.pc;
    assign EX_inst   = ex_q.inst;
    assign EX_rd1    = ex_q.rd1;
    assign EX_rd2    = ex_q.rd2;
    assign EX_imm    = ex_q.imm;
    assign EX_rfwe   = ex_q.rfwe;
    assign EX_wdsel  = ex_q.wdsel;
    assign EX_ctrl   = ex_q.ctrl;
    assign EX_valid  = ex_q.valid;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: default instance plus a CNT_W=4
// instance sharing the same stimulus for counter saturation.
module tb_id_ex_pipe;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk, rst_n;
    logic [31:0] ID_pc, ID_inst, ID_rd1, ID_rd2, ID_imm, fw1, fw2;
    logic        ID_rfwe, dpc_control, flush;
    logic [1:0]  ID_wdsel, rd1_sel, rd2_sel;
    logic [7:0]  ID_ctrl;

    logic [31:0] EX_pc, EX_inst, EX_rd1, EX_rd2, EX_imm;
    logic        EX_rfwe, EX_valid;
    logic [1:0]  EX_wdsel;
    logic [7:0]  EX_ctrl;
    logic [15:0] stall_cnt, flush_cnt;

    logic [31:0] s_pc, s_inst, s_rd1, s_rd2, s_imm;
    logic        s_rfwe, s_valid;
    logic [1:0]  s_wdsel;
    logic [7:0]  s_ctrl;
    logic [3:0]  s_stall, s_flush;

    id_ex_pipe #(.CTRL_W(8), .NOP(NOP), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_pc(ID_pc), .ID_inst(ID_inst), .ID_rd1(ID_rd1),
        .ID_rd2(ID_rd2), .ID_imm(ID_imm), .ID_rfwe(ID_rfwe),
        .ID_wdsel(ID_wdsel), .ID_ctrl(ID_ctrl),
        .rd1_sel(rd1_sel), .rd2_sel(rd2_sel), .fw1(fw1), .fw2(fw2),
        .dpc_control(dpc_control), .flush(flush),
        .EX_pc(EX_pc), .EX_inst(EX_inst), .EX_rd1(EX_rd1),
        .EX_rd2(EX_rd2), .EX_imm(EX_imm), .EX_rfwe(EX_rfwe),
        .EX_wdsel(EX_wdsel), .EX_ctrl(EX_ctrl), .EX_valid(EX_valid),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_pipe #(.CTRL_W(8), .NOP(NOP), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .ID_pc(ID_pc), .ID_inst(ID_inst), .ID_rd1(ID_rd1),
        .ID_rd2(ID_rd2), .ID_imm(ID_imm), .ID_rfwe(ID_rfwe),
        .ID_wdsel(ID_wdsel), .ID_ctrl(ID_ctrl),
        .rd1_sel(rd1_sel), .rd2_sel(rd2_sel), .fw1(fw1), .fw2(fw2),
        .dpc_control(dpc_control), .flush(flush),
        .EX_pc(s_pc), .EX_inst(s_inst), .EX_rd1(s_rd1),
        .EX_rd2(s_rd2), .EX_imm(s_imm), .EX_rfwe(s_rfwe),
        .EX_wdsel(s_wdsel), .EX_ctrl(s_ctrl), .EX_valid(s_valid),
        .stall_cnt(s_stall), .flush_cnt(s_flush)
    );

    typedef struct {
        logic [31:0] pc, inst, rd1, rd2, imm;
        logic        rfwe, valid;
        logic [1:0]  wdsel;
        logic [7:0]  ctrl;
        int          scnt, fcnt, scnt4;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_stall = 0, m_flush = 0, m_stall4 = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".pc"},    EX_pc,    32'h0);
        chk({tag, ".inst"},  EX_inst,  NOP);
        chk({tag, ".rd1"},   EX_rd1,   32'h0);
        chk({tag, ".rd2"},   EX_rd2,   32'h0);
        chk({tag, ".imm"},   EX_imm,   32'h0);
        chk({tag, ".rfwe"},  {31'h0, EX_rfwe}, 32'h0);
        chk({tag, ".wdsel"}, {30'h0, EX_wdsel}, 32'h0);
        chk({tag, ".ctrl"},  {24'h0, EX_ctrl}, 32'h0);
        chk({tag, ".valid"}, {31'h0, EX_valid}, 32'h0);
        chk({tag, ".scnt"},  {16'h0, stall_cnt}, 32'h0);
        chk({tag, ".fcnt"},  {16'h0, flush_cnt}, 32'h0);
        chk({tag, ".scnt4"}, {28'h0, s_stall}, 32'h0);
    endtask

    // Push the expected EX state for the current inputs, clock, then compare.
    task automatic cycle(input string tag);
        exp_t e;
        if (flush || dpc_control) begin
            e.pc = ID_pc; e.inst = NOP; e.rd1 = 0; e.rd2 = 0; e.imm = 0;
            e.rfwe = 0; e.wdsel = 0; e.ctrl = 0; e.valid = 0;
            if (flush) begin
                if (m_flush < 65535) m_flush++;
            end else begin
                if (m_stall < 65535) m_stall++;
                if (m_stall4 < 15) m_stall4++;
            end
        end else begin
            e.pc = ID_pc; e.inst = ID_inst; e.imm = ID_imm;
            e.rd1 = (rd1_sel == 2'd1) ? fw1 : ID_rd1;
            e.rd2 = (rd2_sel == 2'd1) ? fw2 : ID_rd2;
            e.rfwe = ID_rfwe; e.wdsel = ID_wdsel; e.ctrl = ID_ctrl;
            e.valid = 1;
        end
        e.scnt = m_stall; e.fcnt = m_flush; e.scnt4 = m_stall4;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".empty"}, 32'h1, 32'h0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".pc"},    EX_pc,   e.pc);
            chk({tag, ".inst"},  EX_inst, e.inst);
            chk({tag, ".rd1"},   EX_rd1,  e.rd1);
            chk({tag, ".rd2"},   EX_rd2,  e.rd2);
            chk({tag, ".imm"},   EX_imm,  e.imm);
            chk({tag, ".rfwe"},  {31'h0, EX_rfwe}, {31'h0, e.rfwe});
            chk({tag, ".wdsel"}, {30'h0, EX_wdsel}, {30'h0, e.wdsel});
            chk({tag, ".ctrl"},  {24'h0, EX_ctrl}, {24'h0, e.ctrl});
            chk({tag, ".valid"}, {31'h0, EX_valid}, {31'h0, e.valid});
            chk({tag, ".scnt"},  {16'h0, stall_cnt}, e.scnt);
            chk({tag, ".fcnt"},  {16'h0, flush_cnt}, e.fcnt);
            chk({tag, ".scnt4"}, {28'h0, s_stall}, e.scnt4);
        end
        @(negedge clk);
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [31:0] inst,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [1:0] s1, input logic [1:0] s2);
        ID_pc = pc; ID_inst = inst; ID_rd1 = r1; ID_rd2 = r2;
        rd1_sel = s1; rd2_sel = s2;
    endtask

    initial begin
        rst_n = 1'b1;
        set_id(32'h0, 32'h0, 0, 0, 0, 0);
        ID_imm = 0; ID_rfwe = 0; ID_wdsel = 0; ID_ctrl = 0;
        fw1 = 0; fw2 = 0; dpc_control = 0; flush = 0;

        #2 rst_n = 1'b0;
        #1 chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;

        set_id(32'h100, 32'h00208033, 32'd5, 32'd3, 2'd0, 2'd0);
        ID_rfwe = 1; ID_imm = 32'hFFFF_FFF0; ID_wdsel = 2'd1; ID_ctrl = 8'hA5;
        cycle("load");

        set_id(32'h104, 32'h00308133, 32'd7, 32'd9, 2'd1, 2'd2);
        fw1 = 32'hDEAD; fw2 = 32'hBEEF;
        cycle("fwd");

        set_id(32'h108, 32'h0000A183, 32'd1, 32'd2, 2'd3, 2'd1);
        ID_wdsel = 2'd3;
        cycle("fwd2");

        set_id(32'h10C, 32'h00418233, 32'd11, 32'd12, 2'd0, 2'd0);
        dpc_control = 1;
        cycle("stall");
        dpc_control = 0; rd1_sel = 2'd1; fw1 = 32'h1234_5678;
        cycle("reload");

        set_id(32'h110, 32'h00000063, 32'd4, 32'd4, 2'd0, 2'd0);
        flush = 1; dpc_control = 1;
        cycle("flsh+stl");
        dpc_control = 0;
        cycle("flush");
        flush = 0;

        for (int i = 0; i < 12; i++) begin
            set_id($urandom, $urandom, $urandom, $urandom,
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            ID_imm = $urandom; ID_rfwe = 1'($urandom);
            ID_wdsel = 2'($urandom); ID_ctrl = 8'($urandom);
            fw1 = $urandom; fw2 = $urandom;
            flush = ($urandom_range(0, 3) == 0);
            dpc_control = ($urandom_range(0, 3) == 0);
            cycle("rand");
        end
        flush = 0; dpc_control = 0;

        dpc_control = 1;
        cycle("stall_a");
        #2 rst_n = 1'b0;
        #1 chk_reset("midrst");
        exp_q.delete();
        m_stall = 0; m_flush = 0; m_stall4 = 0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            ID_pc = 32'h200 + 32'(i * 4);
            cycle("sat");
        end
        chk("sat.scnt4", {28'h0, s_stall}, 32'hF);
        chk("sat.scnt",  {16'h0, stall_cnt}, 32'd20);
        dpc_control = 0;
        cycle("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
